// File: rtl/seq_shift_add_mult.sv
// -----------------------------------------------------------------------------
// seq_shift_add_mult
//   Iterative unsigned WIDTH x WIDTH shift-and-add multiplier. Each RUN cycle
//   ANDs the shifted multiplicand with the multiplier LSB to form one partial
//   product and adds it into a 2*WIDTH accumulator. The accumulator is the
//   product output.
//
// Ports
//   clk      in   1        rising-edge clock
//   rst_n    in   1        asynchronous active-low reset
//   start    in   1        request, accepted only while ready=1
//   a        in   WIDTH    multiplicand, sampled on the accepting edge
//   b        in   WIDTH    multiplier, sampled on the accepting edge
//   ready    out  1        high in IDLE
//   busy     out  1        high in RUN
//   done     out  1        one-cycle pulse, product valid
//   product  out  2*WIDTH  a*b, held from done until the next accepted start
//
// Configuration
//   EARLY_TERM_EN  when defined, RUN exits as soon as the remaining multiplier
//                  bits are all zero. The result is unchanged and only the
//                  latency shrinks.
// -----------------------------------------------------------------------------
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_IDLE | waiting for start; ready=1
// ST_RUN  | one partial product accumulated per cycle; busy=1
// ST_DONE | product valid, done pulse; returns to IDLE next cycle
//
module seq_shift_add_mult #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] product_q, product_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        product_d = product_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mcand_d   = {{WIDTH{1'b0}}, a};
                    mplier_d  = b;
                    cnt_d     = '0;
                    product_d = '0;
                    state_d   = ST_RUN;
                end
            end

            ST_RUN: begin
                product_d = product_q + (mcand_q & {(2*WIDTH){mplier_q[0]}});
                mcand_d   = mcand_q << 1;
                mplier_d  = mplier_q >> 1;
                // cnt reaches WIDTH on the exit edge; 2**CNT_W > WIDTH keeps it from wrapping
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = ST_DONE;
                end
`ifdef EARLY_TERM_EN
                else if (mplier_d == '0) begin
                    // no set bits left, later partial products would all be zero
                    state_d = ST_DONE;
                end
`endif
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign ready   = (state_q == ST_IDLE);
    assign busy    = (state_q == ST_RUN);
    assign done    = (state_q == ST_DONE);
    assign product = product_q;

endmodule
